pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- irq  in  1  external interrupt request, level
- kernel  in  1  PC[31] of the instruction in ID; 1 = handler running, IRQ masked
- ID_rs, ID_rt  in  5 each  source registers of the ID instruction
- ID_jump  in  1  J/JAL decoded in ID
- ID_jr  in  1  JR/JALR decoded in ID
- ID_illop  in  1  undefined opcode in ID
- EX_MemRead  in  1  load in EX
- EX_rt  in  5  destination of the EX load
- EX_branch_taken  in  1  branch resolved taken in EX
- PCSrc  out  3  PC select: 000 PC+4, 001 branch, 010 jump, 011 jr, 100 IRQ vector, 101 exception vector
- datahazard  out  1  hold PC and IF/ID
- IDEX_flush  out  1  insert bubble into ID/EX
- IRQ_tag  out  1  marks the fetched slot as the interrupt victim for IF/ID
- irq_ack  out  1  one-cycle pulse, registered, on interrupt entry
- stall_count  out  16  saturating count of load-use stall cycles

Function
REQ-003 Load-use hazard SHALL be EX_MemRead & (EX_rt != 0) & (EX_rt == ID_rs | EX_rt == ID_rt).
REQ-004 Per-cycle priority SHALL be: EX_branch_taken > ID_illop > IRQ entry > ID_jump/ID_jr > load-use > sequential.
REQ-005 EX_branch_taken SHALL give PCSrc=001, IDEX_flush=1, datahazard=0, and SHALL suppress the other causes in that cycle.
REQ-006 ID_illop, with no branch, SHALL give PCSrc=101, IDEX_flush=1, regardless of kernel.
REQ-007 ID_jump SHALL give PCSrc=010 and ID_jr SHALL give PCSrc=011, with datahazard=0 and IDEX_flush=0; when load-use coincides with ID_jr, the stall SHALL win and PCSrc SHALL be 000.
REQ-008 Load-use SHALL assert datahazard=1 and IDEX_flush=1 for exactly one cycle, with PCSrc=000.
REQ-009 PCSrc, datahazard, IDEX_flush and IRQ_tag SHALL be combinational from inputs and current state, with zero-cycle latency.
REQ-010 The IRQ FSM SHALL have states IDLE, PEND, TAKE and MASK.
- IDLE -> PEND: irq=1 and kernel=0.
- PEND -> TAKE: next cycle with no branch, illop or load-use; otherwise stay in PEND.
- PEND -> IDLE: irq deasserts before the take.
- TAKE: drives PCSrc=100, IRQ_tag=1, IDEX_flush=1; irq_ack=1 on the following cycle; -> MASK unconditionally.
- MASK -> IDLE: kernel=0 observed for 2 consecutive cycles; a new irq in MASK SHALL be ignored until the return to IDLE.
REQ-011 In TAKE, EX_branch_taken SHALL override (PCSrc=001), the FSM SHALL return to PEND, and irq_ack SHALL NOT pulse.
REQ-012 stall_count SHALL increment on each load-use stall cycle and saturate at 16'hFFFF.
REQ-013 With no cause active, outputs SHALL be PCSrc=000, datahazard=0, IDEX_flush=0, IRQ_tag=0.

Reset
REQ-014 On reset=1 at a clk edge: FSM=IDLE, irq_ack=0, stall_count=0, MASK exit counter cleared.
REQ-015 While reset=1, combinational outputs SHALL be forced to PCSrc=000, datahazard=0, IDEX_flush=0, IRQ_tag=0.
REQ-016 Reset during PEND or TAKE SHALL drop the pending interrupt; a still-asserted irq SHALL re-enter PEND after reset releases.

Structure
REQ-017 The PCSrc encodings (000-101) and the FSM state constants SHALL live in the shared pipeline package, also used by the PC mux and IF/ID register.
REQ-018 The IRQ FSM SHALL be the sub-module irq_sequencer; hazard detection and priority muxing SHALL stay in the top level.

Verification
REQ-019 The bench SHALL cover, at minimum:
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 -> one cycle with datahazard=1, IDEX_flush=1, PCSrc=000; stall_count 0 -> 1.
- EX_rt=0 with ID_rs=0 and EX_MemRead=1 -> no stall.
- Branch plus load-use in the same cycle -> PCSrc=001, datahazard=0, IDEX_flush=1.
- IRQ with kernel=0 -> PEND, then TAKE with PCSrc=100 and IRQ_tag=1; irq_ack pulses once; a second irq during MASK is ignored until kernel=0 holds for 2 cycles.
- irq during a load-use stall -> TAKE delayed one cycle; ID_illop and irq in the same cycle -> PCSrc=101 and FSM stays PEND; 65536 stalls -> stall_count=FFFF held; reset in TAKE -> FSM=IDLE and irq_ack=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: PC select encodings, IRQ sequencer states,
// and the load-use hazard predicate.
package pipe_hazard_ctrl_pkg;

    // PC mux select, also decoded by the PC mux and the IF/ID register
    typedef enum logic [2:0] {
        PcSeq    = 3'b000,
        PcBranch = 3'b001,
        PcJump   = 3'b010,
        PcJr     = 3'b011,
        PcIrq    = 3'b100,
        PcExc    = 3'b101
    } pc_src_e;

    // Interrupt entry sequencer states
    typedef enum logic [1:0] {
        IrqIdle = 2'b00,
        IrqPend = 2'b01,
        IrqTake = 2'b10,
        IrqMask = 2'b11
    } irq_state_e;

    // A load in EX writing a register the ID instruction reads ($0 never hazards)
    function automatic logic load_use_hazard(input logic       mem_read,
                                             input logic [4:0] ex_rt,
                                             input logic [4:0] id_rs,
                                             input logic [4:0] id_rt);
        return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: waits for a clean slot, takes the vector for one
// cycle, then masks further requests until the handler has returned to user code.
module irq_sequencer
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_irq,
    input  logic i_kernel,
    input  logic i_branch,
    input  logic i_illop,
    input  logic i_load_use,
    output logic o_take,
    output logic o_irq_ack
);

    irq_state_e r_state;
    irq_state_e w_state_next;
    logic       r_kzero;        // one kernel=0 cycle already seen while masked
    logic       w_kzero_next;
    logic       r_irq_ack;
    logic       w_ack_next;

    // State register, mask exit counter and registered acknowledge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IrqIdle;
            r_kzero   <= 1'b0;
            r_irq_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_kzero   <= w_kzero_next;
            r_irq_ack <= w_ack_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_kzero_next = 1'b0;
        w_ack_next   = 1'b0;
        case (r_state)
            IrqIdle: begin
                if (i_irq && !i_kernel) w_state_next = IrqPend;
            end
            IrqPend: begin
                if (!i_irq) begin
                    w_state_next = IrqIdle;
                end else if (!(i_branch || i_illop || i_load_use)) begin
                    w_state_next = IrqTake;
                end
            end
            IrqTake: begin
                // A higher-priority redirect steals the slot; retry from PEND
                if (i_branch || i_illop) begin
                    w_state_next = IrqPend;
                end else begin
                    w_state_next = IrqMask;
                    w_ack_next   = 1'b1;
                end
            end
            IrqMask: begin
                if (!i_kernel) begin
                    if (r_kzero) w_state_next = IrqIdle;
                    else         w_kzero_next = 1'b1;
                end
            end
            default: w_state_next = IrqIdle;
        endcase
    end

    assign o_take    = (r_state == IrqTake);
    assign o_irq_ack = r_irq_ack;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, redirect priority muxing,
// interrupt entry via irq_sequencer and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        kernel,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_jump,
    input  logic        ID_jr,
    input  logic        ID_illop,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_branch_taken,
    output logic [2:0]  PCSrc,
    output logic        datahazard,
    output logic        IDEX_flush,
    output logic        IRQ_tag,
    output logic        irq_ack,
    output logic [15:0] stall_count
);

    logic        w_load_use;
    logic        w_take;
    logic [15:0] r_stall_count;

    assign w_load_use = load_use_hazard(EX_MemRead, EX_rt, ID_rs, ID_rt);

    irq_sequencer u_irq_sequencer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_irq      (irq),
        .i_kernel   (kernel),
        .i_branch   (EX_branch_taken),
        .i_illop    (ID_illop),
        .i_load_use (w_load_use),
        .o_take     (w_take),
        .o_irq_ack  (irq_ack)
    );

    // Priority mux: branch > illop > IRQ entry > jump/jr > load-use > sequential
    always_comb begin
        PCSrc      = PcSeq;
        datahazard = 1'b0;
        IDEX_flush = 1'b0;
        IRQ_tag    = 1'b0;
        if (!reset) begin
            if (EX_branch_taken) begin
                PCSrc      = PcBranch;
                IDEX_flush = 1'b1;
            end else if (ID_illop) begin
                PCSrc      = PcExc;
                IDEX_flush = 1'b1;
            end else if (w_take) begin
                PCSrc      = PcIrq;
                IDEX_flush = 1'b1;
                IRQ_tag    = 1'b1;
            end else if (ID_jump) begin
                PCSrc = PcJump;
            end else if (ID_jr && !w_load_use) begin
                // JR reads rs in ID, so a pending load must stall it first
                PCSrc = PcJr;
            end else if (w_load_use) begin
                datahazard = 1'b1;
                IDEX_flush = 1'b1;
            end
        end
    end

    // Saturating count of cycles actually spent stalled on load-use
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (datahazard && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: each cycle's expected outputs are queued when the
// stimulus is applied and compared on the following falling edge.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq = 1'b0;
    logic        kernel = 1'b0;
    logic [4:0]  ID_rs = 5'd0;
    logic [4:0]  ID_rt = 5'd0;
    logic        ID_jump = 1'b0;
    logic        ID_jr = 1'b0;
    logic        ID_illop = 1'b0;
    logic        EX_MemRead = 1'b0;
    logic [4:0]  EX_rt = 5'd0;
    logic        EX_branch_taken = 1'b0;
    logic [2:0]  PCSrc;
    logic        datahazard;
    logic        IDEX_flush;
    logic        IRQ_tag;
    logic        irq_ack;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [2:0]  pc;
        logic        dh;
        logic        fl;
        logic        tag;
        logic        ack;
        logic [15:0] cnt;
        logic        chk_seq;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        reg_known = 1'b0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .irq             (irq),
        .kernel          (kernel),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_jump         (ID_jump),
        .ID_jr           (ID_jr),
        .ID_illop        (ID_illop),
        .EX_MemRead      (EX_MemRead),
        .EX_rt           (EX_rt),
        .EX_branch_taken (EX_branch_taken),
        .PCSrc           (PCSrc),
        .datahazard      (datahazard),
        .IDEX_flush      (IDEX_flush),
        .IRQ_tag         (IRQ_tag),
        .irq_ack         (irq_ack),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Advance to just after the next rising edge and return inputs to idle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset           = 1'b0;
        irq             = 1'b0;
        kernel          = 1'b0;
        ID_rs           = 5'd0;
        ID_rt           = 5'd0;
        ID_jump         = 1'b0;
        ID_jr           = 1'b0;
        ID_illop        = 1'b0;
        EX_MemRead      = 1'b0;
        EX_rt           = 5'd0;
        EX_branch_taken = 1'b0;
    endtask

    // Queue what this cycle must show; stall_count tracks stalls expected so far
    task automatic exp_out(input logic [2:0] pc, input logic dh, input logic fl,
                           input logic tag, input logic ack);
        exp_t e;
        e.pc      = pc;
        e.dh      = dh;
        e.fl      = fl;
        e.tag     = tag;
        e.ack     = ack;
        e.cnt     = exp_cnt;
        e.chk_seq = reg_known;
        sb.push_back(e);
        if (reset) begin
            exp_cnt   = 16'd0;
            reg_known = 1'b1;
        end else if (dh && (exp_cnt != 16'hFFFF)) begin
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pcsrc", 16'(PCSrc), 16'(e.pc));
            check("datahazard", 16'(datahazard), 16'(e.dh));
            check("idex_flush", 16'(IDEX_flush), 16'(e.fl));
            check("irq_tag", 16'(IRQ_tag), 16'(e.tag));
            if (e.chk_seq) begin
                check("irq_ack", 16'(irq_ack), 16'(e.ack));
                check("stall_count", stall_count, e.cnt);
            end
        end
    end

    initial begin
        // Reset; second cycle has every cause active to prove outputs are forced low
        next_cycle(); reset = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); reset = 1; EX_branch_taken = 1; ID_illop = 1; ID_jump = 1;
        EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5; irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // Load-use on rs, then idle
        next_cycle(); EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5; exp_out(PcSeq, 1, 1, 0, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);
        // $0 never hazards
        next_cycle(); EX_MemRead = 1; exp_out(PcSeq, 0, 0, 0, 0);
        // Load-use on rt
        next_cycle(); EX_MemRead = 1; EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3;
        exp_out(PcSeq, 1, 1, 0, 0);
        // Matching register but not a load
        next_cycle(); EX_rt = 5'd7; ID_rs = 5'd7; exp_out(PcSeq, 0, 0, 0, 0);
        // Branch beats load-use
        next_cycle(); EX_branch_taken = 1; EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5;
        exp_out(PcBranch, 0, 1, 0, 0);
        next_cycle(); ID_jump = 1; exp_out(PcJump, 0, 0, 0, 0);
        next_cycle(); ID_jr = 1; exp_out(PcJr, 0, 0, 0, 0);
        // JR with load-use: stall wins
        next_cycle(); ID_jr = 1; EX_MemRead = 1; EX_rt = 5'd9; ID_rs = 5'd9;
        exp_out(PcSeq, 1, 1, 0, 0);
        // Jump outranks load-use
        next_cycle(); ID_jump = 1; EX_MemRead = 1; EX_rt = 5'd9; ID_rs = 5'd9;
        exp_out(PcJump, 0, 0, 0, 0);
        // Illegal op in kernel mode still traps
        next_cycle(); ID_illop = 1; kernel = 1; exp_out(PcExc, 0, 1, 0, 0);

        // IRQ entry: IDLE -> PEND -> TAKE -> MASK
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcIrq, 0, 1, 1, 0);
        next_cycle(); irq = 1; kernel = 1; exp_out(PcSeq, 0, 0, 0, 1);
        next_cycle(); irq = 1; kernel = 1; exp_out(PcSeq, 0, 0, 0, 0);
        // Broken kernel=0 run must not unmask
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; kernel = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        // Back in IDLE: the held irq is accepted again
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcIrq, 0, 1, 1, 0);
        next_cycle(); kernel = 1; exp_out(PcSeq, 0, 0, 0, 1);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // IRQ during load-use: take slips by one cycle
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; EX_MemRead = 1; EX_rt = 5'd4; ID_rt = 5'd4;
        exp_out(PcSeq, 1, 1, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcIrq, 0, 1, 1, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 1);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // Illegal op while pending: trap, FSM stays in PEND
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; ID_illop = 1; exp_out(PcExc, 0, 1, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcIrq, 0, 1, 1, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 1);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // Branch in TAKE: back to PEND, no ack; then reset while in TAKE
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; EX_branch_taken = 1; exp_out(PcBranch, 0, 1, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; reset = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); irq = 1; exp_out(PcIrq, 0, 1, 1, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 1);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // irq withdrawn while pending: PEND -> IDLE, no take
        next_cycle(); irq = 1; exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);

        // Saturation: enough stalls to pass 16'hFFFF and hold there
        for (int i = 0; i < 65540; i++) begin
            next_cycle(); EX_MemRead = 1; EX_rt = 5'd3; ID_rt = 5'd3;
            exp_out(PcSeq, 1, 1, 0, 0);
        end
        next_cycle(); exp_out(PcSeq, 0, 0, 0, 0);
        check("sat_model", exp_cnt, 16'hFFFF);

        @(negedge clk);
        #1;
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
